control_fsm: RTL
================

// Module: control_fsm
// PURPOSE
//   Multi-cycle fetch/execute controller sitting directly upstream of the ALU.
//   Owns the 6-bit PC, instruction register and NZP condition codes; fetches
//   16-bit instructions over a req/valid handshake, decodes them into ALU op,
//   source select, immediate and register-file selects, and resolves branches.
// PARAMETERS
//   RESET_PC  6'd0    PC value loaded on reset
//   CC_RESET  3'b010  NZP value loaded on reset (Z set)
// PORTS
//   clk            in   1   single clock, all state on rising edge
//   reset          in   1   synchronous, active-high
//   ins_req        out  1   instruction fetch request, high only in FETCH
//   ins_addr       out  6   fetch address (= pc)
//   ins_valid      in   1   fetch data valid; ignored unless ins_req high
//   ins_rdata      in   16  instruction word, sampled when ins_req & ins_valid
//   alu_result     in   8   ALU result, used for register write and CC update
//   alu_op         out  2   00 ADD, 01 AND, 10 NOT
//   source_sel     out  2   00 immediate, 01 PC (LEA), 10 register
//   ins_immediate  out  6   ir[5:0]
//   pc             out  6   current PC (address of next instruction during EXEC)
//   sr1_sel/sr2_sel out 3   register-file read selects: ir[8:6] / ir[2:0]
//   dr_sel         out  3   register-file write select: ir[11:9]
//   reg_we         out  1   register-file write enable, one EXEC cycle
//   nzp            out  3   condition codes {N,Z,P}
//   halted         out  1   high in HALT state
//   illegal        out  1   one-cycle pulse on undefined opcode
// BEHAVIOUR
//   Reset: state=FETCH, pc=RESET_PC, ir=0, nzp=CC_RESET; outputs ins_req=1
//     (FETCH), reg_we=0, halted=0, illegal=0. Reset wins over any other event,
//     including a valid fetch in the same cycle; a pending fetch is abandoned.
//   Encoding: ir[15:12] opcode. ADD 0001, AND 0101, NOT 1001, LEA 1110,
//     BR 0000, HALT 1111; all others illegal. ALU ops: ir[5]=1 immediate
//     (source_sel=00, imm5=ir[4:0] sign-extended by ALU), ir[5]=0 register
//     (source_sel=10). NOT: ir[5]=1 inverts immediate, ir[5]=0 inverts SR1.
//     LEA: alu_op=00, source_sel=01, ALU forms pc+ir[5:0]. BR: ir[11:9] mask.
//   States: FETCH, EXEC, HALT.
//   FETCH: ins_req=1, ins_addr=pc. Wait indefinitely. On ins_valid: ir<=ins_rdata,
//     pc<=pc+1 (mod 64, 63 wraps to 0), ->EXEC.
//   EXEC (exactly 1 cycle), decode outputs combinational from ir:
//     ADD/AND/NOT/LEA: reg_we=1; nzp<= {r[7], r==0, ~r[7]&(r!=0)} of alu_result.
//     BR: reg_we=0; if (ir[11:9] & nzp)!=0, pc<=pc+ir[5:0] (6-bit wrap);
//       mask 000 never taken; nzp unchanged.
//     HALT: ->HALT. Illegal: NOP, illegal=1 this cycle, nzp unchanged.
//     Otherwise ->FETCH.
//   HALT: halted=1, ins_req=0, reg_we=0, pc frozen; exit only via reset.
//   Outside EXEC: reg_we=0, alu_op/source_sel still decoded from ir (don't care).
//   Latency: 2 cycles/instruction minimum (ins_valid in first FETCH cycle);
//     each ins_valid stall cycle adds 1.
// TESTING
//   Reset then ins_valid held 1, word 16'h1261 (ADD R1,R1,#1), alu_result=8'h05
//     -> ins_addr=0, next cycle reg_we=1 dr_sel=1 source_sel=00, nzp=001, pc=1.
//   alu_result=8'h80 on AND reg mode (16'h5442) -> source_sel=10, sr2_sel=2, nzp=100;
//     alu_result=0 on next op -> nzp=010.
//   With nzp=010, BR z,+5 (16'h0405) at pc=10 -> pc=16; BR n (16'h0805) -> pc=11.
//   BR taken at pc=62 with offset 6'h03 -> pc wraps 63+3 = 2; fetch from 63 -> pc=0.
//   ins_valid low 3 cycles in FETCH -> ins_req stays 1, pc/ir unchanged, no reg_we.
//   HALT 16'hF000 -> halted=1, ins_req=0 forever; opcode 4'h3 -> illegal pulse,
//     no write; reset asserted mid-FETCH with ins_valid=1 -> pc=RESET_PC, ir=0.

Source files
------------

// File: rtl/control_fsm_if.sv
// rtl/control_fsm_if.sv - instruction fetch handshake between controller and instruction memory
interface control_fsm_if;
    logic        ins_req;
    logic [5:0]  ins_addr;
    logic        ins_valid;
    logic [15:0] ins_rdata;

    modport master (output ins_req, output ins_addr, input ins_valid, input ins_rdata);
    modport slave  (input ins_req, input ins_addr, output ins_valid, output ins_rdata);
endinterface

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - fetch/execute controller: owns PC, IR and NZP, decodes for the ALU
module control_fsm #(
    parameter logic [5:0] RESET_PC = 6'd0,
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic              clk,
    input  logic              reset,
    control_fsm_if.master     fetch,
    input  logic [7:0]        alu_result,
    output logic [1:0]        alu_op,
    output logic [1:0]        source_sel,
    output logic [5:0]        ins_immediate,
    output logic [5:0]        pc,
    output logic [2:0]        sr1_sel,
    output logic [2:0]        sr2_sel,
    output logic [2:0]        dr_sel,
    output logic              reg_we,
    output logic [2:0]        nzp,
    output logic              halted,
    output logic              illegal
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [3:0]  opcode;

    assign opcode        = ir_q[15:12];
    assign ins_immediate = ir_q[5:0];
    assign sr1_sel       = ir_q[8:6];
    assign sr2_sel       = ir_q[2:0];
    assign dr_sel        = ir_q[11:9];
    assign pc            = pc_q;
    assign nzp           = nzp_q;
    assign halted        = (state_q == S_HALT);
    assign fetch.ins_addr = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'd0;
            nzp_q   <= CC_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            nzp_q   <= nzp_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        nzp_d         = nzp_q;
        fetch.ins_req = 1'b0;
        reg_we        = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                fetch.ins_req = 1'b1;
                if (fetch.ins_valid) begin
                    ir_d    = fetch.ins_rdata;
                    pc_d    = pc_q + 6'd1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
                        reg_we = 1'b1;
                        nzp_d  = {alu_result[7], alu_result == 8'd0,
                                  ~alu_result[7] & (alu_result != 8'd0)};
                    end
                    OP_BR: begin
                        // pc already points past the branch, so the offset is PC-relative to the next word
                        if ((ir_q[11:9] & nzp_q) != 3'b000)
                            pc_d = pc_q + ir_q[5:0];
                    end
                    OP_HALT: state_d = S_HALT;
                    default: illegal = 1'b1;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op     = 2'b00;
        source_sel = ir_q[5] ? 2'b00 : 2'b10;
        case (opcode)
            OP_AND: alu_op = 2'b01;
            OP_NOT: alu_op = 2'b10;
            OP_LEA: source_sel = 2'b01;
            default: alu_op = 2'b00;
        endcase
    end
endmodule
